// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage and its branch target buffer.
package fetch_stage_pkg;

   localparam int unsigned XLEN  = 32;
   // BTB tags keep the full word address so the entry layout does not depend on depth.
   localparam int unsigned TAG_W = XLEN - 2;

   // addi x0,x0,0
   localparam logic [XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            pred_taken;
      logic            pc_predicted;
      logic [XLEN-1:0] pred_pc;
   } decode_stage_pipe_reg_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  target;
      logic [1:0]       ctr;
   } btb_entry_t;

   // Saturating 2-bit direction counter.
   function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken && ctr != 2'b11) begin
         res = ctr + 2'd1;
      end else if (!taken && ctr != 2'b00) begin
         res = ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Ports:
//   clk, rst           clock, async active-low reset (clears all entries)
//   lookup_pc          PC looked up combinationally
//   hit_c/taken_c      tag match / counter MSB for lookup_pc
//   target_c           stored target for lookup_pc
//   upd_*              resolved-branch update from execute
module fetch_btb
   import fetch_stage_pkg::*;
#(
   parameter int unsigned ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lookup_pc,
   output logic        hit_c,
   output logic        taken_c,
   output logic [31:0] target_c,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   btb_entry_t       tbl [ENTRIES];
   logic [IDX_W-1:0] l_idx;
   logic [IDX_W-1:0] u_idx;
   logic             u_hit;
   logic             unused_pc_bits;

   assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

   assign l_idx = lookup_pc[IDX_W+1:2];
   assign u_idx = upd_pc[IDX_W+1:2];

   // Lookup reads the registered table, so a same-cycle update is not visible yet.
   assign hit_c    = tbl[l_idx].valid && (tbl[l_idx].tag == lookup_pc[31:2]);
   assign taken_c  = tbl[l_idx].ctr[1];
   assign target_c = tbl[l_idx].target;

   assign u_hit = tbl[u_idx].valid && (tbl[u_idx].tag == upd_pc[31:2]);

   // Hits train the counter; only taken misses allocate.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tbl[IDX_W'(i)] <= '0;
         end
      end else if (upd_valid) begin
         if (u_hit) begin
            tbl[u_idx].ctr <= ctr_update(tbl[u_idx].ctr, upd_taken);
         end else if (upd_taken) begin
            tbl[u_idx] <= '{valid: 1'b1, tag: upd_pc[31:2], target: upd_target, ctr: 2'b10};
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, runs the imem req/ack handshake and drives the
// fetch->decode pipe register. Handles decode stall (HOLD) and mispredict
// redirect (DRAIN discards the in-flight word when a request is outstanding).
// Optional macro FETCH_BTB_EN adds a direct-mapped BTB for next-PC prediction.
// Ports:
//   clk, rst                     clock, async active-low reset
//   imem_req/addr/ack/rdata      instruction memory handshake
//   stall, branch_miss/target    controller stall, execute redirect
//   upd_*                        BTB training (ignored without FETCH_BTB_EN)
//   nxt_*                        registered fields for decode
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] NOP_INST    = DEFAULT_NOP_INST,
   parameter int unsigned BTB_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_miss,
   input  logic [31:0] branch_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   output logic        nxt_valid,
   output logic [31:0] nxt_pc,
   output logic [31:0] nxt_inst,
   output logic        nxt_pred_taken,
   output logic        nxt_pc_predicted,
   output logic [31:0] nxt_pred_pc
);

   localparam decode_stage_pipe_reg_t BUBBLE = '{
      valid: 1'b0, pc: '0, inst: NOP_INST,
      pred_taken: 1'b0, pc_predicted: 1'b0, pred_pc: '0
   };

   fetch_state_e           state;
   logic [31:0]            pc;
   logic [31:0]            addr_q;
   logic                   req_q;
   decode_stage_pipe_reg_t pipe_q;
   decode_stage_pipe_reg_t buf_q;
   logic [31:0]            buf_next_pc;

   logic                   ack_c;
   logic [31:0]            pc_plus4_c;
   logic                   pred_taken_c;
   logic                   pc_predicted_c;
   logic [31:0]            pred_pc_c;
   logic [31:0]            next_pc_c;
   decode_stage_pipe_reg_t fetched_c;

   assign pc_plus4_c = pc + 32'd4;

`ifdef FETCH_BTB_EN
   logic        btb_hit_c;
   logic        btb_taken_c;
   logic [31:0] btb_target_c;

   fetch_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
      .clk        (clk),
      .rst        (rst),
      .lookup_pc  (pc),
      .hit_c      (btb_hit_c),
      .taken_c    (btb_taken_c),
      .target_c   (btb_target_c),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_target (upd_target),
      .upd_taken  (upd_taken)
   );

   assign pc_predicted_c = btb_hit_c;
   assign pred_taken_c   = btb_hit_c & btb_taken_c;
   assign pred_pc_c      = btb_hit_c ? btb_target_c : pc_plus4_c;
`else
   logic unused_upd;
   assign unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken, 32'(BTB_ENTRIES)};

   assign pc_predicted_c = 1'b0;
   assign pred_taken_c   = 1'b0;
   assign pred_pc_c      = pc_plus4_c;
`endif

   // A taken prediction implies a hit, so pred_pc_c is the BTB target then.
   assign next_pc_c = pred_taken_c ? pred_pc_c : pc_plus4_c;

   // Acks only count against an issued request.
   assign ack_c = req_q & imem_ack;

   assign fetched_c = '{
      valid: 1'b1, pc: pc, inst: imem_rdata,
      pred_taken: pred_taken_c, pc_predicted: pc_predicted_c, pred_pc: pred_pc_c
   };

   // Fetch control, PC and pipe register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         addr_q      <= RESET_PC;
         req_q       <= 1'b0;
         pipe_q      <= BUBBLE;
         buf_q       <= BUBBLE;
         buf_next_pc <= '0;
      end else if (branch_miss) begin
         pipe_q <= BUBBLE;
         buf_q  <= BUBBLE;
         pc     <= branch_target;
         // An outstanding request must complete at its old address before refetching.
         if (req_q && !imem_ack) begin
            state <= DRAIN;
         end else begin
            state  <= FETCH;
            addr_q <= branch_target;
            req_q  <= 1'b1;
         end
      end else begin
         case (state)
            FETCH: begin
               req_q <= 1'b1;
               if (ack_c && !stall) begin
                  pipe_q <= fetched_c;
                  pc     <= next_pc_c;
                  addr_q <= next_pc_c;
               end else if (ack_c) begin
                  buf_q       <= fetched_c;
                  buf_next_pc <= next_pc_c;
                  req_q       <= 1'b0;
                  state       <= HOLD;
               end else if (!stall) begin
                  pipe_q <= BUBBLE;
               end
            end
            HOLD: begin
               if (!stall) begin
                  pipe_q <= buf_q;
                  buf_q  <= BUBBLE;
                  pc     <= buf_next_pc;
                  addr_q <= buf_next_pc;
                  req_q  <= 1'b1;
                  state  <= FETCH;
               end
            end
            DRAIN: begin
               if (imem_ack) begin
                  addr_q <= pc;
                  state  <= FETCH;
               end
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

   assign imem_req         = req_q;
   assign imem_addr        = addr_q;
   assign nxt_valid        = pipe_q.valid;
   assign nxt_pc           = pipe_q.pc;
   assign nxt_inst         = pipe_q.inst;
   assign nxt_pred_taken   = pipe_q.pred_taken;
   assign nxt_pc_predicted = pipe_q.pc_predicted;
   assign nxt_pred_pc      = pipe_q.pred_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a randomized run checked
// against an instruction-stream model (sequential PCs, redirect on mispredict).
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_miss;
   logic [31:0] branch_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        nxt_valid;
   logic [31:0] nxt_pc;
   logic [31:0] nxt_inst;
   logic        nxt_pred_taken;
   logic        nxt_pc_predicted;
   logic [31:0] nxt_pred_pc;

   // Second instance with wrapping reset PC, fed by an always-ready memory.
   logic        req2;
   logic [31:0] addr2;
   logic [31:0] rdata2;
   logic        valid2;
   logic [31:0] pc2;
   logic [31:0] inst2;
   logic        pt2;
   logic        pp2;
   logic [31:0] ppc2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign rdata2 = mem(addr2);

   fetch_stage dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .branch_miss(branch_miss), .branch_target(branch_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
      .nxt_valid(nxt_valid), .nxt_pc(nxt_pc), .nxt_inst(nxt_inst),
      .nxt_pred_taken(nxt_pred_taken), .nxt_pc_predicted(nxt_pc_predicted), .nxt_pred_pc(nxt_pred_pc)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst),
      .imem_req(req2), .imem_addr(addr2), .imem_ack(req2), .imem_rdata(rdata2),
      .stall(1'b0), .branch_miss(1'b0), .branch_target(32'h0),
      .upd_valid(1'b0), .upd_pc(32'h0), .upd_target(32'h0), .upd_taken(1'b0),
      .nxt_valid(valid2), .nxt_pc(pc2), .nxt_inst(inst2),
      .nxt_pred_taken(pt2), .nxt_pc_predicted(pp2), .nxt_pred_pc(ppc2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs (memory answers only an outstanding request), then sample point.
   task automatic step(input bit st, input bit acken, input bit miss, input logic [31:0] tgt);
      stall         = st;
      branch_miss   = miss;
      branch_target = tgt;
      imem_ack      = acken & imem_req;
      imem_rdata    = mem(imem_addr);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      stall = 1'b0; branch_miss = 1'b0; branch_target = '0; imem_ack = 1'b0; imem_rdata = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] prev_addr;
      logic [31:0] tgt;
      bit          prev_req;
      bit          prev_ack;
      bit          last_miss;
      bit          st;
      bit          miss;
      bit          acken;
      bit          found;
      int          consumed;
      logic [31:0] exp_t6_pp;
      logic [31:0] exp_t6_next;
      logic        exp_t6_taken;

      // Reset state
      do_reset();
      rst = 1'b0;
      check("rst_valid", 32'(nxt_valid), 32'd0);
      check("rst_inst", nxt_inst, 32'h13);
      check("rst_pc", nxt_pc, 32'h0);
      check("rst_pred_pc", nxt_pred_pc, 32'h0);
      check("rst_req", 32'(imem_req), 32'd0);
      rst = 1'b1;

      // 1: streaming with ack tied high; first cycle is a bubble
      step(0, 1, 0, 0);
      check("t1_first_bubble", 32'(nxt_valid), 32'd0);
      check("t1_req_up", 32'(imem_req), 32'd1);
      check("t1_addr", imem_addr, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 0);
         check("t1_valid", 32'(nxt_valid), 32'd1);
         check("t1_pc", nxt_pc, 32'(i * 4));
         check("t1_inst", nxt_inst, mem(32'(i * 4)));
         // 5: wrapping reset PC on the second instance
         if (i == 0) check("t5_pc_wrap_first", pc2, 32'hFFFF_FFFC);
         if (i == 1) check("t5_pc_wrap_zero", pc2, 32'h0);
      end

      // 2: stall during the ack of 0x10
      step(1, 1, 0, 0);
      check("t2_hold_pc", nxt_pc, 32'h0C);
      check("t2_hold_req", 32'(imem_req), 32'd0);
      step(1, 1, 0, 0);
      check("t2_hold_pc2", nxt_pc, 32'h0C);
      check("t2_hold_req2", 32'(imem_req), 32'd0);
      step(1, 1, 0, 0);
      check("t2_hold_pc3", nxt_pc, 32'h0C);
      step(0, 1, 0, 0);
      check("t2_release_pc", nxt_pc, 32'h10);
      check("t2_release_inst", nxt_inst, mem(32'h10));
      step(0, 1, 0, 0);
      check("t2_no_dup", nxt_pc, 32'h14);

      // 3: mispredict while stalled
      step(1, 1, 1, 32'h100);
      check("t3_flush_valid", 32'(nxt_valid), 32'd0);
      check("t3_flush_inst", nxt_inst, 32'h13);
      step(0, 1, 0, 0);
      check("t3_target_pc", nxt_pc, 32'h100);
      check("t3_target_valid", 32'(nxt_valid), 32'd1);

      // 4: mispredict with request pending, ack two cycles later
      step(0, 0, 1, 32'h200);
      check("t4_drain_req", 32'(imem_req), 32'd1);
      check("t4_drain_addr", imem_addr, 32'h104);
      step(0, 0, 0, 0);
      check("t4_drain_addr2", imem_addr, 32'h104);
      step(0, 1, 0, 0);
      check("t4_dropped", 32'(nxt_valid), 32'd0);
      check("t4_refetch_addr", imem_addr, 32'h200);
      step(0, 1, 0, 0);
      check("t4_target_pc", nxt_pc, 32'h200);
      check("t4_target_inst", nxt_inst, mem(32'h200));

      // Randomized run: decode consumes nxt_* on every unstalled, unflushed cycle
      do_reset();
      exp_pc = 32'h0; last_miss = 0; prev_req = 0; prev_ack = 0; prev_addr = '0; consumed = 0;
      for (int c = 0; c < 600; c++) begin
         st    = ($urandom_range(0, 3) == 0);
         miss  = ($urandom_range(0, 24) == 0);
         acken = ($urandom_range(0, 2) != 0);
         tgt   = 32'($urandom_range(0, 16'hFFFF)) << 2;
         if (last_miss) begin
            check("rnd_flush_valid", 32'(nxt_valid), 32'd0);
            check("rnd_flush_inst", nxt_inst, 32'h13);
         end
         if (prev_req && !prev_ack) begin
            check("rnd_req_held", 32'(imem_req), 32'd1);
            check("rnd_addr_stable", imem_addr, prev_addr);
         end
         if (!st && !miss && nxt_valid) begin
            check("rnd_pc", nxt_pc, exp_pc);
            check("rnd_inst", nxt_inst, mem(exp_pc));
            check("rnd_pred_pc", nxt_pred_pc, exp_pc + 32'd4);
            check("rnd_pred_taken", 32'(nxt_pred_taken), 32'd0);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (miss) exp_pc = tgt;
         prev_req  = imem_req;
         prev_addr = imem_addr;
         prev_ack  = acken & imem_req;
         last_miss = miss;
         step(st, acken, miss, tgt);
      end
      check("rnd_progress", 32'(consumed > 100), 32'd1);

      // 6: BTB training and prediction
`ifdef FETCH_BTB_EN
      exp_t6_taken = 1'b1; exp_t6_pp = 32'h80; exp_t6_next = 32'h80;
`else
      exp_t6_taken = 1'b0; exp_t6_pp = 32'h24; exp_t6_next = 32'h24;
`endif
      do_reset();
      upd_valid = 1'b1; upd_pc = 32'h20; upd_target = 32'h80; upd_taken = 1'b1;
      step(0, 1, 0, 0);
      upd_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(0, 1, 0, 0);
         if (nxt_valid && nxt_pc == 32'h20) found = 1;
      end
      check("t6_reached_0x20", 32'(found), 32'd1);
      check("t6_pred_taken", 32'(nxt_pred_taken), 32'(exp_t6_taken));
      check("t6_pc_predicted", 32'(nxt_pc_predicted), 32'(exp_t6_taken));
      check("t6_pred_pc", nxt_pred_pc, exp_t6_pp);
      step(0, 1, 0, 0);
      check("t6_next_pc", nxt_pc, exp_t6_next);

      // Not-taken update on a hit weakens the counter; redirect back to 0x20
      upd_valid = 1'b1; upd_pc = 32'h20; upd_target = 32'h80; upd_taken = 1'b0;
      step(0, 1, 1, 32'h20);
      upd_valid = 1'b0;
      check("t6b_flush", 32'(nxt_valid), 32'd0);
      step(0, 1, 0, 0);
      check("t6b_pc", nxt_pc, 32'h20);
      check("t6b_pred_taken", 32'(nxt_pred_taken), 32'd0);
`ifdef FETCH_BTB_EN
      check("t6b_pc_predicted", 32'(nxt_pc_predicted), 32'd1);
      check("t6b_pred_pc", nxt_pred_pc, 32'h80);
`else
      check("t6b_pc_predicted", 32'(nxt_pc_predicted), 32'd0);
      check("t6b_pred_pc", nxt_pred_pc, 32'h24);
`endif
      step(0, 1, 0, 0);
      check("t6b_next_pc", nxt_pc, 32'h24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
